// File: rtl/systolic_fpga_example_pkg.sv
`default_nettype none
// ============================================================================
// systolic_fpga_example_pkg : shared types for the vadd job scheduler
// Revision 1.0
// ============================================================================
package systolic_fpga_example_pkg;

    localparam int JOB_ADDR_W  = 64;
    localparam int JOB_BYTES_W = 32;
    localparam int JOB_CONST_W = 32;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_START = 3'd2,
        ST_WAIT  = 3'd3,
        ST_HALT  = 3'd4
    } sched_state_t;

    typedef struct packed {
        logic [JOB_ADDR_W-1:0]  addr;
        logic [JOB_BYTES_W-1:0] bytes;
        logic [JOB_CONST_W-1:0] constant;
    } job_desc_t;

endpackage
`default_nettype wire

// File: rtl/systolic_fpga_example_job_fifo.sv
`default_nettype none
// ============================================================================
// systolic_fpga_example_job_fifo : synchronous job FIFO, head visible on pop_data
// Revision 1.0
// ============================================================================
module systolic_fpga_example_job_fifo #(
    parameter int WIDTH = 128,
    parameter int DEPTH = 4
) (
    input  logic             aclk,
    input  logic             areset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign empty    = (wr_ptr == rd_ptr);
    // Extra pointer bit distinguishes full from empty when the indices match.
    assign full     = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign pop_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge aclk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule
`default_nettype wire

// File: rtl/systolic_fpga_example_vadd_scheduler.sv
`default_nettype none
// ============================================================================
// systolic_fpga_example_vadd_scheduler : splits queued jobs into vadd chunk runs
// Revision 1.0
// ============================================================================
module systolic_fpga_example_vadd_scheduler #(
    parameter int C_M_AXI_ADDR_WIDTH = 64,
    parameter int C_XFER_SIZE_WIDTH  = 32,
    parameter int C_ADDER_BIT_WIDTH  = 32,
    parameter int C_CHUNK_BYTES      = 65536,
    parameter int C_FIFO_DEPTH       = 4,
    parameter int C_TIMEOUT_CYCLES   = 2**20
) (
    input  logic                          aclk,
    input  logic                          areset_n,
    input  logic                          s_job_valid,
    output logic                          s_job_ready,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0] s_job_addr,
    input  logic [C_XFER_SIZE_WIDTH-1:0]  s_job_bytes,
    input  logic [C_ADDER_BIT_WIDTH-1:0]  s_job_constant,
    output logic                          vadd_ap_start,
    input  logic                          vadd_ap_done,
    output logic [C_M_AXI_ADDR_WIDTH-1:0] vadd_addr_offset,
    output logic [C_XFER_SIZE_WIDTH-1:0]  vadd_xfer_size_in_bytes,
    output logic [C_ADDER_BIT_WIDTH-1:0]  vadd_constant,
    output logic                          job_done,
    output logic                          job_error,
    output logic                          busy
);
    import systolic_fpga_example_pkg::*;

    localparam int                           TW    = $clog2(C_TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0]                LIMIT = TW'(C_TIMEOUT_CYCLES - 1);
    localparam logic [C_XFER_SIZE_WIDTH-1:0] CHUNK = C_XFER_SIZE_WIDTH'(C_CHUNK_BYTES);

    sched_state_t                  state;
    sched_state_t                  state_nx;
    job_desc_t                     push_job;
    job_desc_t                     head_job;
    logic                          fifo_full;
    logic                          fifo_empty;
    logic                          push;
    logic                          pop;
    logic                          advance;
    logic                          done_set;
    logic                          error_set;
    logic [C_M_AXI_ADDR_WIDTH-1:0] cur_addr;
    logic [C_XFER_SIZE_WIDTH-1:0]  remaining;
    logic [C_ADDER_BIT_WIDTH-1:0]  cur_constant;
    logic [TW-1:0]                 wait_cnt;
    logic [C_XFER_SIZE_WIDTH-1:0]  chunk;
    logic [C_M_AXI_ADDR_WIDTH-1:0] addr_nx;
    logic [C_XFER_SIZE_WIDTH-1:0]  rem_nx;
    logic [C_XFER_SIZE_WIDTH-1:0]  chunk_nx;

    assign s_job_ready   = !fifo_full && (state != ST_HALT);
    assign push          = s_job_valid && s_job_ready;
    assign vadd_ap_start = (state == ST_START);
    assign busy          = (state != ST_IDLE) || !fifo_empty;

    always_comb begin
        push_job = '0;
        push_job.addr[C_M_AXI_ADDR_WIDTH-1:0]    = s_job_addr;
        push_job.bytes[C_XFER_SIZE_WIDTH-1:0]    = s_job_bytes;
        push_job.constant[C_ADDER_BIT_WIDTH-1:0] = s_job_constant;
    end

    systolic_fpga_example_job_fifo #(
        .WIDTH ($bits(job_desc_t)),
        .DEPTH (C_FIFO_DEPTH)
    ) u_job_fifo (
        .aclk      (aclk),
        .areset_n  (areset_n),
        .push      (push),
        .push_data (push_job),
        .pop       (pop),
        .pop_data  (head_job),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Chunk never exceeds what is left of the job.
    assign chunk    = (remaining < CHUNK) ? remaining : CHUNK;
    assign addr_nx  = advance ? cur_addr + C_M_AXI_ADDR_WIDTH'(chunk) : cur_addr;
    assign rem_nx   = advance ? remaining - chunk : remaining;
    assign chunk_nx = (rem_nx < CHUNK) ? rem_nx : CHUNK;

    always_comb begin
        state_nx  = state;
        pop       = 1'b0;
        advance   = 1'b0;
        done_set  = 1'b0;
        error_set = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop      = 1'b1;
                    state_nx = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (remaining == '0) begin
                    done_set = 1'b1;
                    state_nx = ST_IDLE;
                end else if (remaining[5:0] != 6'd0) begin
                    error_set = 1'b1;
                    state_nx  = ST_HALT;
                end else begin
                    state_nx = ST_START;
                end
            end
            ST_START: state_nx = ST_WAIT;
            ST_WAIT: begin
                // A done arriving on the expiry cycle still wins over the timeout.
                if (vadd_ap_done) begin
                    advance = 1'b1;
                    if (remaining == chunk) begin
                        done_set = 1'b1;
                        state_nx = ST_IDLE;
                    end else begin
                        state_nx = ST_START;
                    end
                end else if (wait_cnt == LIMIT) begin
                    error_set = 1'b1;
                    state_nx  = ST_HALT;
                end
            end
            ST_HALT: state_nx = ST_HALT;
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) state <= ST_IDLE;
        else           state <= state_nx;
    end

    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            cur_addr                <= '0;
            remaining               <= '0;
            cur_constant            <= '0;
            wait_cnt                <= '0;
            job_done                <= 1'b0;
            job_error               <= 1'b0;
            vadd_addr_offset        <= '0;
            vadd_xfer_size_in_bytes <= '0;
            vadd_constant           <= '0;
        end else begin
            job_done <= done_set;
            if (error_set) job_error <= 1'b1;
            if (pop) begin
                cur_addr     <= head_job.addr[C_M_AXI_ADDR_WIDTH-1:0];
                remaining    <= head_job.bytes[C_XFER_SIZE_WIDTH-1:0];
                cur_constant <= head_job.constant[C_ADDER_BIT_WIDTH-1:0];
            end else begin
                cur_addr  <= addr_nx;
                remaining <= rem_nx;
            end
            if (state == ST_WAIT) wait_cnt <= wait_cnt + TW'(1);
            else                  wait_cnt <= '0;
            // Chunk configuration is latched on entry to START and held until the next one.
            if (state_nx == ST_START) begin
                vadd_addr_offset        <= addr_nx;
                vadd_xfer_size_in_bytes <= chunk_nx;
                vadd_constant           <= cur_constant;
            end
        end
    end

endmodule
`default_nettype wire
